cpu_run_ctrl: RTL and testbench

//  Boot/run sequencer for simple_cpu. Loads a program byte-stream into the 16x8 instruction memory

---
 rtl/cpu_ctrl_pkg.sv | 25 ++
 rtl/run_watchdog.sv | 38 +++
 rtl/cpu_run_ctrl.sv | 119 +++++++++++
 tb/tb_cpu_run_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and sizes for the simple_cpu boot/run controller.
// The imem geometry here is the same one simple_cpu is built with.
package cpu_ctrl_pkg;

   localparam int IMEM_DEPTH = 16;
   localparam int ADDR_W     = 4;
   localparam int DATA_W     = 8;

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(IMEM_DEPTH);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      ARM  = 3'd2,
      RUN  = 3'd3,
      DONE = 3'd4,
      TOUT = 3'd5
   } run_state_t;

   // Requested lengths beyond the memory size load the whole memory.
   function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
      return (len > DEPTH_L) ? DEPTH_L : len;
   endfunction

endpackage

// File: rtl/run_watchdog.sv
// RUN-cycle counter with synchronous clear and a limit compare.
// expired_o flags the cycle whose increment reaches WDOG_LIMIT.
module run_watchdog #(
   parameter int WDOG_W     = 16,
   parameter int WDOG_LIMIT = 1000
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              en_i,
   output logic [WDOG_W-1:0] cycles_o,
   output logic              expired_o
);

   localparam logic [WDOG_W-1:0] LAST = WDOG_W'(WDOG_LIMIT - 1);

   logic [WDOG_W-1:0] cycles_q;
   logic [WDOG_W-1:0] cycles_d;

   always_comb begin
      cycles_d = cycles_q;
      if (clear_i)
         cycles_d = '0;
      else if (en_i)
         cycles_d = cycles_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         cycles_q <= '0;
      else
         cycles_q <= cycles_d;
   end

   assign cycles_o  = cycles_q;
   assign expired_o = en_i && (cycles_q == LAST);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Boot/run sequencer: streams a program into imem with the CPU held in reset,
// releases the CPU, then waits for halt or watchdog expiry.
module cpu_run_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int WDOG_W     = 16,
   parameter int WDOG_LIMIT = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   load_len,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              cpu_rst,
   input  logic              cpu_halt,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [WDOG_W-1:0] cycles
);

   run_state_t        state_q;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   ptr_q;
   logic              imem_we_q;
   logic [ADDR_W-1:0] imem_addr_q;
   logic [DATA_W-1:0] imem_wdata_q;
   logic              cpu_rst_q;
   logic              done_q;
   logic              timeout_q;

   logic              idle_like;
   logic              start_acc;
   logic              wdog_exp;

   assign idle_like = (state_q == IDLE) || (state_q == DONE) || (state_q == TOUT);
   assign start_acc = start && idle_like;

   run_watchdog #(
      .WDOG_W     (WDOG_W),
      .WDOG_LIMIT (WDOG_LIMIT)
   ) u_wdog (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .clear_i   (start_acc),
      .en_i      (state_q == RUN),
      .cycles_o  (cycles),
      .expired_o (wdog_exp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         len_q        <= '0;
         ptr_q        <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         cpu_rst_q    <= 1'b1;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         imem_we_q <= 1'b0;
         case (state_q)
            IDLE, DONE, TOUT: begin
               if (start) begin
                  len_q     <= clamp_len(load_len);
                  ptr_q     <= '0;
                  done_q    <= 1'b0;
                  timeout_q <= 1'b0;
                  cpu_rst_q <= 1'b1;
                  state_q   <= (load_len == '0) ? ARM : LOAD;
               end
            end
            LOAD: begin
               if (s_valid) begin
                  imem_we_q    <= 1'b1;
                  imem_addr_q  <= ptr_q[ADDR_W-1:0];
                  imem_wdata_q <= s_data;
                  ptr_q        <= ptr_q + 1'b1;
                  if (ptr_q == len_q - 1'b1)
                     state_q <= ARM;
               end
            end
            // One settle cycle so the last write lands before the first fetch.
            ARM: begin
               cpu_rst_q <= 1'b0;
               state_q   <= RUN;
            end
            RUN: begin
               if (cpu_halt) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else if (wdog_exp) begin
                  timeout_q <= 1'b1;
                  cpu_rst_q <= 1'b1;
                  state_q   <= TOUT;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s_ready    = (state_q == LOAD);
   assign busy       = (state_q == LOAD) || (state_q == ARM) || (state_q == RUN);
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign cpu_rst    = cpu_rst_q;
   assign done       = done_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl with a tiny behavioural CPU (LDI=x5, JMP=x6, HLT=xF, others NOP).
module tb_cpu_run_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [4:0]  load_len;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic        imem_we;
   logic [3:0]  imem_addr;
   logic [7:0]  imem_wdata;
   logic        cpu_rst;
   logic        cpu_halt;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [15:0] cycles;

   always #5 clk = ~clk;

   cpu_run_ctrl #(.WDOG_W(16), .WDOG_LIMIT(20)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .load_len   (load_len),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .cpu_halt   (cpu_halt),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .cycles     (cycles)
   );

   // Behavioural imem + CPU; halt decodes the instruction at pc.
   logic [7:0] tb_imem [16];
   logic [3:0] pc;
   logic [7:0] acc;
   logic       m_halt;
   logic       use_model;
   logic       tb_halt;
   logic [7:0] cur;

   assign cur      = tb_imem[pc];
   assign m_halt   = !cpu_rst && (cur[3:0] == 4'hF);
   assign cpu_halt = use_model ? m_halt : tb_halt;

   always @(posedge clk) begin
      if (imem_we) tb_imem[imem_addr] <= imem_wdata;
      if (cpu_rst) begin
         pc  <= 4'd0;
         acc <= 8'd0;
      end else if (!m_halt) begin
         case (cur[3:0])
            4'h5: begin acc <= {4'h0, cur[7:4]}; pc <= pc + 4'd1; end
            4'h6: pc <= cur[7:4];
            default: pc <= pc + 4'd1;
         endcase
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   logic [7:0] prog [16];

   task automatic start_job(input logic [4:0] len);
      start = 1'b1;
      load_len = len;
      @(posedge clk); #1;
      start = 1'b0;
      load_len = 5'd0;
   endtask

   task automatic stream(input int n);
      int sent = 0;
      int guard = 0;
      logic a;
      while (sent < n && guard < 64) begin
         s_valid = 1'b1;
         s_data  = prog[sent];
         #1;
         a = s_ready;
         @(posedge clk); #1;
         guard++;
         if (a) begin
            chk("load_we", 32'(imem_we), 32'd1);
            chk("load_addr", 32'(imem_addr), 32'(sent));
            sent++;
         end
      end
      s_valid = 1'b0;
      chk("stream_count", 32'(sent), 32'(n));
   endtask

   task automatic wait_idle(input int max);
      int k = 0;
      while (busy && k < max) begin
         @(posedge clk); #1;
         k++;
      end
      chk("wait_idle", 32'(busy), 32'd0);
   endtask

   typedef struct {
      logic        start;
      logic [4:0]  len;
      logic        sv;
      logic [7:0]  sd;
      logic        halt;
      logic        e_rdy;
      logic        e_we;
      logic [3:0]  e_addr;
      logic [7:0]  e_wd;
      logic        e_rst;
      logic        e_busy;
      logic        e_done;
      logic        e_to;
      logic [15:0] e_cyc;
   } vec_t;

   vec_t tv [8];

   initial begin
      rst_n = 1'b0; start = 1'b0; load_len = 5'd0; s_valid = 1'b0; s_data = 8'd0;
      tb_halt = 1'b0; use_model = 1'b0;
      for (int i = 0; i < 16; i++) prog[i] = 8'h00;

      //           st len  sv  sd    h  | rdy we addr wd    rst busy done to cyc
      tv[0] = '{1'b1, 5'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
      tv[1] = '{1'b0, 5'd0, 1'b1, 8'h25, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
      tv[2] = '{1'b0, 5'd0, 1'b1, 8'h13, 1'b0, 1'b1, 1'b1, 4'd0, 8'h25, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
      tv[3] = '{1'b0, 5'd0, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b1, 4'd1, 8'h13, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
      tv[4] = '{1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
      tv[5] = '{1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd2, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
      tv[6] = '{1'b0, 5'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd2, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
      tv[7] = '{1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd2, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2};

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(s_ready), 32'd0);
      chk("rst_cycles", 32'(cycles), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Test 1: cycle-exact load of 3 bytes, then ARM/RUN/DONE
      for (int i = 0; i < 8; i++) begin
         start = tv[i].start; load_len = tv[i].len; s_valid = tv[i].sv;
         s_data = tv[i].sd; tb_halt = tv[i].halt;
         #1;
         chk($sformatf("t1[%0d].s_ready", i), 32'(s_ready), 32'(tv[i].e_rdy));
         chk($sformatf("t1[%0d].imem_we", i), 32'(imem_we), 32'(tv[i].e_we));
         chk($sformatf("t1[%0d].imem_addr", i), 32'(imem_addr), 32'(tv[i].e_addr));
         chk($sformatf("t1[%0d].imem_wdata", i), 32'(imem_wdata), 32'(tv[i].e_wd));
         chk($sformatf("t1[%0d].cpu_rst", i), 32'(cpu_rst), 32'(tv[i].e_rst));
         chk($sformatf("t1[%0d].busy", i), 32'(busy), 32'(tv[i].e_busy));
         chk($sformatf("t1[%0d].done", i), 32'(done), 32'(tv[i].e_done));
         chk($sformatf("t1[%0d].timeout", i), 32'(timeout), 32'(tv[i].e_to));
         chk($sformatf("t1[%0d].cycles", i), 32'(cycles), 32'(tv[i].e_cyc));
         @(posedge clk); #1;
      end
      start = 1'b0; s_valid = 1'b0; tb_halt = 1'b0;
      use_model = 1'b1;

      // Test 2: LDI 2 / HLT
      prog[0] = 8'h25; prog[1] = 8'h0F;
      start_job(5'd2);
      stream(2);
      wait_idle(60);
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_timeout", 32'(timeout), 32'd0);
      chk("t2_acc", 32'(acc), 32'h02);
      chk("t2_cycles", 32'(cycles), 32'd2);
      repeat (3) @(posedge clk);
      #1;
      chk("t2_cpu_rst_low", 32'(cpu_rst), 32'd0);

      // Test 3: JMP 0 forever -> watchdog
      prog[0] = 8'h06;
      start_job(5'd1);
      stream(1);
      wait_idle(60);
      chk("t3_timeout", 32'(timeout), 32'd1);
      chk("t3_done", 32'(done), 32'd0);
      chk("t3_cycles", 32'(cycles), 32'd20);
      chk("t3_cpu_rst", 32'(cpu_rst), 32'd1);

      // Test 4: bubbles and an ignored start during LOAD
      prog[0] = 8'h15; prog[1] = 8'h25; prog[2] = 8'h35; prog[3] = 8'h0F;
      start_job(5'd4);
      begin
         int sent = 0;
         int cyc = 0;
         logic a;
         while (sent < 4 && cyc < 20) begin
            s_valid  = (cyc % 2 == 0);
            s_data   = prog[sent];
            start    = (cyc == 3);
            load_len = (cyc == 3) ? 5'd2 : 5'd0;
            #1;
            chk("t4_ready", 32'(s_ready), 32'd1);
            a = s_valid && s_ready;
            @(posedge clk); #1;
            chk($sformatf("t4_we_c%0d", cyc), 32'(imem_we), 32'(a));
            if (a) begin
               chk("t4_addr", 32'(imem_addr), 32'(sent));
               chk("t4_wdata", 32'(imem_wdata), 32'(prog[sent]));
               sent++;
            end
            cyc++;
         end
         s_valid = 1'b0; start = 1'b0; load_len = 5'd0;
         chk("t4_beats", 32'(sent), 32'd4);
      end
      chk("t4_arm_busy", 32'(busy), 32'd1);
      chk("t4_arm_ready", 32'(s_ready), 32'd0);
      chk("t4_arm_cpu_rst", 32'(cpu_rst), 32'd1);
      wait_idle(60);
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_acc", 32'(acc), 32'h03);

      // Test 5: async reset mid-LOAD, then full and clamped loads
      prog[0] = 8'hAA; prog[1] = 8'hBB;
      start_job(5'd8);
      stream(2);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_state_busy", 32'(busy), 32'd0);
      chk("t5_rst_ready", 32'(s_ready), 32'd0);
      chk("t5_rst_we", 32'(imem_we), 32'd0);
      chk("t5_rst_addr", 32'(imem_addr), 32'd0);
      chk("t5_rst_wdata", 32'(imem_wdata), 32'd0);
      chk("t5_rst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("t5_rst_done", 32'(done), 32'd0);
      chk("t5_rst_timeout", 32'(timeout), 32'd0);
      chk("t5_rst_cycles", 32'(cycles), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      prog[0] = 8'h75;
      for (int i = 1; i < 15; i++) prog[i] = 8'h00;
      prog[15] = 8'h0F;
      start_job(5'd16);
      stream(16);
      wait_idle(80);
      chk("t5_full_done", 32'(done), 32'd1);
      chk("t5_full_acc", 32'(acc), 32'h07);
      chk("t5_full_cycles", 32'(cycles), 32'd16);

      prog[0] = 8'h95;
      start_job(5'd20);
      begin
         int accd = 0;
         logic a;
         for (int c = 0; c < 20; c++) begin
            s_valid = 1'b1;
            s_data  = prog[(accd < 16) ? accd : 15];
            #1;
            a = s_ready;
            @(posedge clk); #1;
            if (a) accd++;
         end
         s_valid = 1'b0;
         chk("t5_clamp_beats", 32'(accd), 32'd16);
      end
      wait_idle(80);
      chk("t5_clamp_done", 32'(done), 32'd1);
      chk("t5_clamp_acc", 32'(acc), 32'h09);
      chk("t5_clamp_cycles", 32'(cycles), 32'd16);

      // Test 6: re-run existing imem from DONE
      start_job(5'd0);
      chk("t6_arm_busy", 32'(busy), 32'd1);
      chk("t6_arm_ready", 32'(s_ready), 32'd0);
      chk("t6_arm_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("t6_done_cleared", 32'(done), 32'd0);
      chk("t6_cycles_cleared", 32'(cycles), 32'd0);
      @(posedge clk); #1;
      chk("t6_run_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("t6_run_busy", 32'(busy), 32'd1);
      wait_idle(80);
      chk("t6_done", 32'(done), 32'd1);
      chk("t6_timeout", 32'(timeout), 32'd0);
      chk("t6_acc", 32'(acc), 32'h09);
      chk("t6_cycles", 32'(cycles), 32'd16);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
